// File: rtl/gpr_bank_if.sv
// Bus bundle between decode/writeback and gpr_bank: write, pair, read, lock and bank-swap signals.
interface gpr_bank_if #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int AW   = 3
) ();
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              pair_wr_en;
    logic [2*DW-1:0]   pair_wr_data;
    logic [AW-1:0]     ds1_rx;
    logic [AW-1:0]     ds2_rx;
    logic [DW-1:0]     ds1_data;
    logic [DW-1:0]     ds2_data;
    logic              ds1_busy;
    logic              ds2_busy;
    logic [2*DW-1:0]   pair_data;
    logic              lock_en;
    logic [AW-1:0]     lock_addr;
    logic              bank_swap;
    logic              bank_sel;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, pair_wr_en, pair_wr_data,
        output ds1_rx, ds2_rx, lock_en, lock_addr, bank_swap,
        input  ds1_data, ds2_data, ds1_busy, ds2_busy, pair_data, bank_sel, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, pair_wr_en, pair_wr_data,
        input  ds1_rx, ds2_rx, lock_en, lock_addr, bank_swap,
        output ds1_data, ds2_data, ds1_busy, ds2_busy, pair_data, bank_sel, busy_vec
    );
endinterface

// File: rtl/gpr_bank.sv
// Dual-bank register file with pair port and busy scoreboard.
// Define GPR_BYPASS_EN to forward same-cycle writes/clears to the read ports and pair output.
module gpr_bank #(
    parameter int DW        = 8,
    parameter int NREG      = 8,
    parameter int AW        = 3,
    parameter int PAIR_BASE = 6
) (
    input  logic     clk,
    input  logic     rst,
    gpr_bank_if.slave bus
);
    logic [DW-1:0]   bank0_r [NREG];
    logic [DW-1:0]   bank1_r [NREG];
    logic            bank_sel_r;
    logic [NREG-1:0] busy_r;

    logic [NREG-1:0] wen_s;
    logic [NREG-1:0] lock_s;
    logic [DW-1:0]   wdata_s  [NREG];
    logic [DW-1:0]   cur_s    [NREG];
    logic [DW-1:0]   rd_val_s [NREG];
    logic [NREG-1:0] rd_busy_s;
    logic [DW-1:0]   ds1_data_s;
    logic [DW-1:0]   ds2_data_s;
    logic            ds1_busy_s;
    logic            ds2_busy_s;

    // Per-register write/lock decode; the pair write outranks the single write on the pair registers.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            wen_s[i]   = 1'b0;
            wdata_s[i] = {DW{1'b0}};
            lock_s[i]  = rst && bus.lock_en && !bus.bank_swap && (bus.lock_addr == AW'(i));
            if (rst && bus.pair_wr_en && (i == PAIR_BASE)) begin
                wen_s[i]   = 1'b1;
                wdata_s[i] = bus.pair_wr_data[2*DW-1:DW];
            end else if (rst && bus.pair_wr_en && (i == PAIR_BASE + 1)) begin
                wen_s[i]   = 1'b1;
                wdata_s[i] = bus.pair_wr_data[DW-1:0];
            end else if (rst && bus.wr_en && (bus.wr_addr == AW'(i))) begin
                wen_s[i]   = 1'b1;
                wdata_s[i] = bus.wr_data;
            end else begin
                wen_s[i]   = 1'b0;
                wdata_s[i] = {DW{1'b0}};
            end
        end
    end

    // Active-bank view of every register, optionally with same-cycle forwarding.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cur_s[i] = bank_sel_r ? bank1_r[i] : bank0_r[i];
`ifdef GPR_BYPASS_EN
            rd_val_s[i]  = wen_s[i] ? wdata_s[i] : cur_s[i];
            rd_busy_s[i] = lock_s[i] | (busy_r[i] & ~wen_s[i]);
`else
            rd_val_s[i]  = cur_s[i];
            rd_busy_s[i] = busy_r[i];
`endif
        end
    end

    // Read-port muxes; selects that match no register leave data and busy at zero.
    always_comb begin
        ds1_data_s = {DW{1'b0}};
        ds2_data_s = {DW{1'b0}};
        ds1_busy_s = 1'b0;
        ds2_busy_s = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            ds1_data_s = (bus.ds1_rx == AW'(i)) ? rd_val_s[i]  : ds1_data_s;
            ds1_busy_s = (bus.ds1_rx == AW'(i)) ? rd_busy_s[i] : ds1_busy_s;
            ds2_data_s = (bus.ds2_rx == AW'(i)) ? rd_val_s[i]  : ds2_data_s;
            ds2_busy_s = (bus.ds2_rx == AW'(i)) ? rd_busy_s[i] : ds2_busy_s;
        end
    end

    // Storage update; writes land in the bank active before any swap in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                bank0_r[i] <= {DW{1'b0}};
                bank1_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wen_s[i] && bank_sel_r) begin
                    bank1_r[i] <= wdata_s[i];
                end else if (wen_s[i]) begin
                    bank0_r[i] <= wdata_s[i];
                end
            end
        end
    end

    // Bank select and scoreboard; a swap starts the new bank with nothing pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_sel_r <= 1'b0;
            busy_r     <= {NREG{1'b0}};
        end else if (bus.bank_swap) begin
            bank_sel_r <= ~bank_sel_r;
            busy_r     <= {NREG{1'b0}};
        end else begin
            busy_r     <= lock_s | (busy_r & ~wen_s);
        end
    end

    assign bus.ds1_data  = ds1_data_s;
    assign bus.ds2_data  = ds2_data_s;
    assign bus.ds1_busy  = ds1_busy_s;
    assign bus.ds2_busy  = ds2_busy_s;
    assign bus.pair_data = {rd_val_s[PAIR_BASE], rd_val_s[PAIR_BASE+1]};
    assign bus.bank_sel  = bank_sel_r;
    assign bus.busy_vec  = busy_r;
endmodule

// File: tb/tb_gpr_bank.sv
// Bench for gpr_bank: an 8-register and a 6-register instance share one directed stimulus stream.
module tb_gpr_bank;
    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        pair_wr_en;
    logic [15:0] pair_wr_data;
    logic [2:0]  ds1_rx;
    logic [2:0]  ds2_rx;
    logic        lock_en;
    logic [2:0]  lock_addr;
    logic        bank_swap;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    gpr_bank_if #(.DW(8), .NREG(8), .AW(3)) bus8 ();
    gpr_bank_if #(.DW(8), .NREG(6), .AW(3)) bus6 ();

    gpr_bank #(.DW(8), .NREG(8), .AW(3), .PAIR_BASE(6)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    gpr_bank #(.DW(8), .NREG(6), .AW(3), .PAIR_BASE(4)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

    assign bus8.wr_en = wr_en;               assign bus6.wr_en = wr_en;
    assign bus8.wr_addr = wr_addr;           assign bus6.wr_addr = wr_addr;
    assign bus8.wr_data = wr_data;           assign bus6.wr_data = wr_data;
    assign bus8.pair_wr_en = pair_wr_en;     assign bus6.pair_wr_en = pair_wr_en;
    assign bus8.pair_wr_data = pair_wr_data; assign bus6.pair_wr_data = pair_wr_data;
    assign bus8.ds1_rx = ds1_rx;             assign bus6.ds1_rx = ds1_rx;
    assign bus8.ds2_rx = ds2_rx;             assign bus6.ds2_rx = ds2_rx;
    assign bus8.lock_en = lock_en;           assign bus6.lock_en = lock_en;
    assign bus8.lock_addr = lock_addr;       assign bus6.lock_addr = lock_addr;
    assign bus8.bank_swap = bank_swap;       assign bus6.bank_swap = bank_swap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: [instance][bank][register], instance 0 = NREG 8, instance 1 = NREG 6.
    bit [7:0] m_mem  [2][2][8];
    bit       m_sel  [2];
    bit       m_busy [2][8];

    function automatic int nreg_of(int d);
        return (d == 1) ? 6 : 8;
    endfunction

    function automatic int pb_of(int d);
        return (d == 1) ? 4 : 6;
    endfunction

    // {written, value} for register r this cycle under the write/priority rules.
    function automatic logic [8:0] new_val(int d, int r);
        if (!rst || r >= nreg_of(d)) return 9'h000;
        if (pair_wr_en && r == pb_of(d))     return {1'b1, pair_wr_data[15:8]};
        if (pair_wr_en && r == pb_of(d) + 1) return {1'b1, pair_wr_data[7:0]};
        if (wr_en && int'(wr_addr) == r)     return {1'b1, wr_data};
        return 9'h000;
    endfunction

    function automatic bit lock_hit(int d, int r);
        return rst && lock_en && !bank_swap && int'(lock_addr) == r && r < nreg_of(d);
    endfunction

    function automatic logic [7:0] exp_data(int d, int r);
        logic [8:0] nv;
        nv = new_val(d, r);
        if (r >= nreg_of(d)) return 8'h00;
        if (BYP && nv[8]) return nv[7:0];
        return m_mem[d][m_sel[d]][r];
    endfunction

    function automatic logic exp_busy(int d, int r);
        logic [8:0] nv;
        nv = new_val(d, r);
        if (r >= nreg_of(d)) return 1'b0;
        if (BYP && lock_hit(d, r)) return 1'b1;
        if (BYP && nv[8]) return 1'b0;
        return m_busy[d][r];
    endfunction

    function automatic logic [7:0] exp_busy_vec(int d);
        logic [7:0] v;
        v = 8'h00;
        for (int r = 0; r < nreg_of(d); r++) v[r] = m_busy[d][r];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_sel[d] = 1'b0;
            for (int r = 0; r < 8; r++) begin
                m_busy[d][r]   = 1'b0;
                m_mem[d][0][r] = 8'h00;
                m_mem[d][1][r] = 8'h00;
            end
        end
    endtask

    always @(negedge rst) model_clear();

    // Advance the reference state at each edge out of reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                logic [8:0] nv [8];
                bit         lk [8];
                for (int r = 0; r < 8; r++) begin
                    nv[r] = new_val(d, r);
                    lk[r] = lock_hit(d, r);
                end
                for (int r = 0; r < nreg_of(d); r++) begin
                    if (nv[r][8]) m_mem[d][m_sel[d]][r] = nv[r][7:0];
                    if (bank_swap)  m_busy[d][r] = 1'b0;
                    else if (lk[r]) m_busy[d][r] = 1'b1;
                    else if (nv[r][8]) m_busy[d][r] = 1'b0;
                end
                if (bank_swap) m_sel[d] = ~m_sel[d];
            end
        end
    end

    task automatic cmp_dut(input int d, input logic [7:0] d1, input logic [7:0] d2, input logic b1,
                           input logic b2, input logic [15:0] pd, input logic bs, input logic [7:0] bv);
        string t;
        t = (d == 1) ? "n6" : "n8";
        check({t, ".ds1_data"}, d1, exp_data(d, int'(ds1_rx)));
        check({t, ".ds2_data"}, d2, exp_data(d, int'(ds2_rx)));
        check({t, ".ds1_busy"}, b1, exp_busy(d, int'(ds1_rx)));
        check({t, ".ds2_busy"}, b2, exp_busy(d, int'(ds2_rx)));
        check({t, ".pair_data"}, pd, {exp_data(d, pb_of(d)), exp_data(d, pb_of(d) + 1)});
        check({t, ".bank_sel"}, bs, m_sel[d]);
        check({t, ".busy_vec"}, bv, exp_busy_vec(d));
    endtask

    // Every negative edge: both instances against the reference.
    always @(negedge clk) begin
        cmp_dut(0, bus8.ds1_data, bus8.ds2_data, bus8.ds1_busy, bus8.ds2_busy,
                bus8.pair_data, bus8.bank_sel, bus8.busy_vec);
        cmp_dut(1, bus6.ds1_data, bus6.ds2_data, bus6.ds1_busy, bus6.ds2_busy,
                bus6.pair_data, bus6.bank_sel, {2'b00, bus6.busy_vec});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; pair_wr_en = 1'b0; lock_en = 1'b0; bank_swap = 1'b0;
    endtask

    typedef struct {
        bit we; bit [2:0] wa; bit [7:0] wd; bit pe; bit [15:0] pd;
        bit le; bit [2:0] la; bit sw; bit [2:0] r1; bit [2:0] r2;
    } vec_t;

    vec_t vecs [8] = '{
        '{1'b1, 3'd0, 8'h5A, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0},
        '{1'b1, 3'd4, 8'hC3, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd4, 3'd0},
        '{1'b0, 3'd0, 8'h00, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd4, 3'd3},
        '{1'b0, 3'd0, 8'h00, 1'b1, 16'hBEEF, 1'b1, 3'd7, 1'b0, 3'd6, 3'd7},
        '{1'b1, 3'd7, 8'h01, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b0, 3'd7, 3'd5},
        '{1'b0, 3'd0, 8'h00, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd4, 3'd6},
        '{1'b1, 3'd5, 8'h99, 1'b1, 16'hCAFE, 1'b1, 3'd5, 1'b0, 3'd5, 3'd4},
        '{1'b0, 3'd0, 8'h00, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd5, 3'd7}
    };

    initial begin
        rst = 1'b0;
        idle();
        wr_addr = 3'd0; wr_data = 8'h00; pair_wr_data = 16'h0000;
        ds1_rx = 3'd0; ds2_rx = 3'd0; lock_addr = 3'd0;
        model_clear();

        // Reset state
        @(negedge clk);
        check("rst.ds1_data", bus8.ds1_data, 8'h00);
        check("rst.pair_data", bus8.pair_data, 16'h0000);
        check("rst.bank_sel", bus8.bank_sel, 1'b0);
        check("rst.busy_vec", bus8.busy_vec, 8'h00);
        tick();
        rst = 1'b1;

        // Write R3 and read it the same cycle and the next
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; ds2_rx = 3'd3;
        @(negedge clk);
        check("lit.same_cycle_r3", bus8.ds2_data, BYP ? 8'hA5 : 8'h00);
        tick();
        idle(); ds1_rx = 3'd3;
        @(negedge clk);
        check("lit.r3_next", bus8.ds1_data, 8'hA5);
        check("lit.n6_r3_next", bus6.ds1_data, 8'hA5);

        // Pair write beats a single write to R6
        tick();
        pair_wr_en = 1'b1; pair_wr_data = 16'h1234; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hFF;
        tick();
        idle(); ds1_rx = 3'd6; ds2_rx = 3'd7;
        @(negedge clk);
        check("lit.r6_pair", bus8.ds1_data, 8'h12);
        check("lit.r7_pair", bus8.ds2_data, 8'h34);
        check("lit.pair_data", bus8.pair_data, 16'h1234);
        check("lit.n6_pair_data", bus6.pair_data, 16'h1234);
        check("lit.n6_addr6_ignored", bus6.ds1_data, 8'h00);

        // Shadow bank preservation
        tick(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h11;
        tick(); idle(); bank_swap = 1'b1;
        tick(); idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h22;
        tick(); idle(); bank_swap = 1'b1;
        tick(); idle(); ds1_rx = 3'd1;
        @(negedge clk);
        check("lit.bank0_r1", bus8.ds1_data, 8'h11);
        check("lit.bank_sel0", bus8.bank_sel, 1'b0);
        tick(); bank_swap = 1'b1;
        tick(); idle();
        @(negedge clk);
        check("lit.bank1_r1", bus8.ds1_data, 8'h22);
        check("lit.bank_sel1", bus8.bank_sel, 1'b1);
        tick(); bank_swap = 1'b1;
        tick(); idle();

        // Scoreboard
        lock_en = 1'b1; lock_addr = 3'd2;
        tick(); idle(); ds1_rx = 3'd2;
        @(negedge clk);
        check("lit.busy_r2", bus8.busy_vec, 8'h04);
        check("lit.ds1_busy_r2", bus8.ds1_busy, 1'b1);
        tick(); lock_en = 1'b1; lock_addr = 3'd2; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h55;
        tick(); idle();
        @(negedge clk);
        check("lit.lock_beats_write", bus8.busy_vec, 8'h04);
        tick(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h66;
        tick(); idle();
        @(negedge clk);
        check("lit.write_clears", bus8.busy_vec, 8'h00);
        tick(); lock_en = 1'b1; lock_addr = 3'd5;
        tick(); idle();
        @(negedge clk);
        check("lit.busy_r5", bus8.busy_vec, 8'h20);
        tick(); bank_swap = 1'b1;
        tick(); idle();
        @(negedge clk);
        check("lit.swap_clears_busy", bus8.busy_vec, 8'h00);
        tick(); bank_swap = 1'b1;
        tick(); idle();

        // Address 7: real register in the 8-deep bank, absent in the 6-deep one
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h77; lock_en = 1'b1; lock_addr = 3'd7;
        tick(); idle(); ds1_rx = 3'd7; ds2_rx = 3'd7;
        @(negedge clk);
        check("lit.n8_r7", bus8.ds1_data, 8'h77);
        check("lit.n8_busy_r7", bus8.busy_vec, 8'h80);
        check("lit.n6_r7_data", bus6.ds1_data, 8'h00);
        check("lit.n6_r7_busy", bus6.ds1_busy, 1'b0);
        check("lit.n6_busy_vec", bus6.busy_vec, 6'h00);

        // Reset asserted mid-write
        tick(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h99; ds1_rx = 3'd3;
        #3 rst = 1'b0;
        @(negedge clk);
        check("lit.mid_reset_r3", bus8.ds1_data, 8'h00);
        check("lit.n6_mid_reset_pair", bus6.pair_data, 16'h0000);
        tick(); rst = 1'b1; idle();
        @(negedge clk);
        check("lit.after_reset_r3", bus8.ds1_data, 8'h00);

        // Directed mixed vectors, checked by the reference each cycle
        for (int i = 0; i < 8; i++) begin
            tick();
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            pair_wr_en = vecs[i].pe; pair_wr_data = vecs[i].pd;
            lock_en = vecs[i].le; lock_addr = vecs[i].la; bank_swap = vecs[i].sw;
            ds1_rx = vecs[i].r1; ds2_rx = vecs[i].r2;
        end
        tick(); idle();
        repeat (2) tick();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised general-purpose register file for the UR408-class core, the successor to the fixed 8×8 `gpr`. It provides:
- two combinational read ports;
- one addressed write port and one register-pair write port;
- a dual-bank shadow set for fast interrupt context switching;
- a per-register busy scoreboard for pending multi-cycle loads.

It sits between decode (read selects) and writeback (write ports), and feeds the pair output to the address/jump path.

## Interface
Parameters:
- `DW`, 8, data width of one register
- `NREG`, 8, registers per bank (2..256)
- `AW`, 3, address width; must satisfy 2^AW ≥ NREG
- `PAIR_BASE`, 6, index of the pair's high register; low register is `PAIR_BASE+1`; requires `PAIR_BASE+1 < NREG`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  single-register write enable
- `wr_addr`  in  AW  write target
- `wr_data`  in  DW  write value
- `pair_wr_en`  in  1  pair write enable
- `pair_wr_data`  in  2*DW  value `{R[PAIR_BASE], R[PAIR_BASE+1]}`
- `ds1_rx`, `ds2_rx`  in  AW  read selects
- `ds1_data`, `ds2_data`  out  DW  read data
- `ds1_busy`, `ds2_busy`  out  1  busy bit of the selected register
- `pair_data`  out  2*DW  `{R[PAIR_BASE], R[PAIR_BASE+1]}` of the active bank
- `lock_en`  in  1  mark `lock_addr` busy
- `lock_addr`  in  AW  register to lock
- `bank_swap`  in  1  toggle active bank at the next edge
- `bank_sel`  out  1  active bank index
- `busy_vec`  out  NREG  busy bit per register

## Operation
- Storage is two banks of NREG×DW flops. All reads and writes address the active bank, `bank_sel`.
- Reset (`rst`=0, asynchronous): all registers in both banks = 0; `bank_sel`=0; `busy_vec`=0. Consequently every output reads 0.
- Reads are combinational from the active bank. A read address ≥ NREG returns 0 and busy 0.
- A write with `wr_en` and `wr_addr` < NREG updates that register at the edge. `wr_addr` ≥ NREG is ignored.
- A pair write updates both pair registers at the edge.
- If `wr_en` targets a pair register in the same cycle as `pair_wr_en`, the pair write wins for that register.
- Writes in a cycle with `bank_swap`=1 commit to the current (old) bank.
- `bank_swap`: `bank_sel` toggles at the edge and the shadow bank's contents are preserved. `busy_vec` clears to 0 on swap; `lock_en` in the swap cycle is ignored.
- Scoreboard:
  - `lock_en` sets `busy[lock_addr]`.
  - Any write (single or pair) to a register clears its busy bit.
  - If a set and a clear hit the same register in one cycle, the set wins.
  - `lock_addr` ≥ NREG is ignored.

## Timing
- Write-to-storage latency is 1 cycle. Read latency is 0 (combinational).
- `bank_sel` and `busy_vec` are registered and change only on the clock edge or on reset.
- Reset assertion mid-cycle clears state immediately. Deassertion is taken synchronously by the next edge; no write is lost in the cycle after deassertion.
- Back-to-back writes to the same address: the last one wins, and each is visible the cycle after.

## Configuration
- `GPR_BYPASS_EN` defined: write forwarding.
  - `dsN_data` returns `wr_data` (or the matching half of `pair_wr_data`, with pair priority) when that port addresses a register being written in the same cycle.
  - This applies to the old bank in swap cycles.
  - `dsN_busy` and `pair_data` are forwarded likewise: busy reads 0 if cleared this cycle, unless a lock also hits.
- Not defined: reads return the pre-write storage value; the new value appears one cycle later.

## Test plan
- Reset with DW=8, NREG=8: all `dsN_data`=0x00, `pair_data`=0x0000, `bank_sel`=0, `busy_vec`=0x00; reset asserted mid-write leaves the register at 0.
- Write R3=0xA5, then read `ds1_rx`=3 → 0xA5 next cycle. With `GPR_BYPASS_EN`, same-cycle `ds2_rx`=3 → 0xA5; without it, → the old value 0x00.
- Same cycle: `pair_wr_en` with 0x1234 and `wr_en` R6=0xFF → R6=0x12, R7=0x34, `pair_data`=0x1234.
- Write R1=0x11, swap, write R1=0x22, swap → `ds1_data`(R1)=0x11 and `bank_sel`=0. Swap once more → 0x22.
- Lock R2 → `busy_vec`=0x04 and `ds1_busy`=1 for R2. Lock and write R2 in the same cycle → stays busy. Plain write R2 → busy cleared. Lock R5 then swap → `busy_vec`=0x00.
- NREG=6, AW=3, PAIR_BASE=4: writing/locking address 7 has no effect; reading address 7 → data 0, busy 0.
